rv_reg_file: RTL and testbench

//  Integer register file (x0..x31) of the single-cycle RISC-V core; directly upstream of the R-type ALU.

---
 rtl/rv_reg_file_if.sv | 24 ++
 rtl/rv_reg_file.sv | 62 ++++++
 tb/tb_rv_reg_file.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_reg_file_if.sv
// Register-file port bundle: instruction decode, writeback and debug read.
// The core side (master) drives instr/writeback/debug address; the register file (slave) returns operands.
interface rv_reg_file_if #(
  parameter int unsigned XLEN = 32
) ();
  logic [31:0]     instr;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      dbg_addr;
  logic [XLEN-1:0] dbg_data;

  modport master (
    output instr, wb_en, wb_rd, wb_data, dbg_addr,
    input  rs1_data, rs2_data, dbg_data
  );

  modport slave (
    input  instr, wb_en, wb_rd, wb_data, dbg_addr,
    output rs1_data, rs2_data, dbg_data
  );
endinterface

// File: rtl/rv_reg_file.sv
// RISC-V integer register file x0..x31: two combinational operand reads, one debug read, one write per clock.
// Optional macro RF_BYPASS_EN forwards a same-cycle writeback onto rs1/rs2 (never onto the debug port).
module rv_reg_file #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic         clk,
  input  logic         rst,
  rv_reg_file_if.slave bus
);

  // Entry 0 has no storage; reads of x0 are forced to zero.
  logic [XLEN-1:0] r_regs [1:NREGS-1];

  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic       w_wr;
  logic       w_byp_rs1;
  logic       w_byp_rs2;
  logic       w_unused_instr;

  assign w_rs1          = bus.instr[19:15];
  assign w_rs2          = bus.instr[24:20];
  assign w_unused_instr = ^{bus.instr[31:25], bus.instr[14:0]};
  assign w_wr           = bus.wb_en && (bus.wb_rd != '0);

  function automatic logic [XLEN-1:0] rd_reg(input logic [4:0] addr);
    if (addr == '0) begin
      return '0;
    end
    return r_regs[addr];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 1; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr) begin
      r_regs[bus.wb_rd] <= bus.wb_data;
    end
  end

`ifdef RF_BYPASS_EN
  always_comb begin
    w_byp_rs1 = !rst && w_wr && (bus.wb_rd == w_rs1);
    w_byp_rs2 = !rst && w_wr && (bus.wb_rd == w_rs2);
  end
`else
  always_comb begin
    w_byp_rs1 = 1'b0;
    w_byp_rs2 = 1'b0;
  end
`endif

  always_comb begin
    bus.rs1_data = w_byp_rs1 ? bus.wb_data : rd_reg(w_rs1);
    bus.rs2_data = w_byp_rs2 ? bus.wb_data : rd_reg(w_rs2);
    bus.dbg_data = rd_reg(bus.dbg_addr);
  end

endmodule

// File: tb/tb_rv_reg_file.sv
// Directed self-checking bench for rv_reg_file; expectations follow the RF_BYPASS_EN setting of the build.
module tb_rv_reg_file;
  localparam int unsigned XLEN = 32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rv_reg_file_if #(.XLEN(XLEN)) rf_if ();

  rv_reg_file #(.XLEN(XLEN), .NREGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (rf_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] rd, input logic [31:0] data);
    rf_if.wb_en   = 1'b1;
    rf_if.wb_rd   = rd;
    rf_if.wb_data = data;
    tick();
    rf_if.wb_en   = 1'b0;
  endtask

  function automatic logic [31:0] mk_instr(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 15'b0};
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rf_if.dbg_addr = 5'(i);
      #1;
      checks++;
      if (rf_if.dbg_data !== 32'h0) begin
        errors++;
        $display("FAIL reset_init x%0d: got %h want 00000000", i, rf_if.dbg_data);
      end
    end
    wr(5'd5, 32'hDEADBEEF);
    rf_if.dbg_addr = 5'd5;
    #1;
    checks++;
    if (rf_if.dbg_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL preload_x5: got %h want deadbeef", rf_if.dbg_data);
    end
    // Reset with a colliding writeback; bypass must not leak the writeback value.
    rf_if.instr   = mk_instr(5'd5, 5'd5);
    rst           = 1'b1;
    rf_if.wb_en   = 1'b1;
    rf_if.wb_rd   = 5'd5;
    rf_if.wb_data = 32'h1;
    #1;
    d = rf_if.rs1_data;
    checks++;
    if (d !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL reset_no_bypass: got %h want deadbeef", d);
    end
    tick();
    rst         = 1'b0;
    rf_if.wb_en = 1'b0;
    #1;
    checks++;
    if (rf_if.rs1_data !== 32'h0 || rf_if.rs2_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_x5_ops: got %h/%h want 0/0", rf_if.rs1_data, rf_if.rs2_data);
    end
    for (int i = 0; i < 32; i++) begin
      rf_if.dbg_addr = 5'(i);
      #1;
      checks++;
      if (rf_if.dbg_data !== 32'h0) begin
        errors++;
        $display("FAIL reset_clear x%0d: got %h want 00000000", i, rf_if.dbg_data);
      end
    end
  endtask

  task automatic test_write_read();
    wr(5'd1, 32'h00000007);
    wr(5'd2, 32'hFFFFFFF9);
    rf_if.instr = 32'h002081B3;
    #1;
    checks++;
    if (rf_if.rs1_data !== 32'h00000007) begin
      errors++;
      $display("FAIL add_rs1: got %h want 00000007", rf_if.rs1_data);
    end
    checks++;
    if (rf_if.rs2_data !== 32'hFFFFFFF9) begin
      errors++;
      $display("FAIL add_rs2: got %h want fffffff9", rf_if.rs2_data);
    end
    // Bits outside [24:15] must not affect decode.
    rf_if.instr = 32'hFE20FFFF & 32'hFE20FFFF;
    rf_if.instr = 32'hFE208FFF;
    #1;
    checks++;
    if (rf_if.rs1_data !== 32'h00000007 || rf_if.rs2_data !== 32'hFFFFFFF9) begin
      errors++;
      $display("FAIL ignore_bits: got %h/%h want 00000007/fffffff9", rf_if.rs1_data, rf_if.rs2_data);
    end
  endtask

  task automatic test_x0();
    wr(5'd0, 32'h12345678);
    rf_if.instr    = mk_instr(5'd0, 5'd0);
    rf_if.dbg_addr = 5'd0;
    #1;
    checks++;
    if (rf_if.rs1_data !== 32'h0 || rf_if.rs2_data !== 32'h0) begin
      errors++;
      $display("FAIL x0_ops: got %h/%h want 0/0", rf_if.rs1_data, rf_if.rs2_data);
    end
    checks++;
    if (rf_if.dbg_data !== 32'h0) begin
      errors++;
      $display("FAIL x0_dbg: got %h want 00000000", rf_if.dbg_data);
    end
    // Same-cycle write to x0 must not bypass either.
    rf_if.wb_en   = 1'b1;
    rf_if.wb_rd   = 5'd0;
    rf_if.wb_data = 32'hCAFEF00D;
    #1;
    checks++;
    if (rf_if.rs1_data !== 32'h0) begin
      errors++;
      $display("FAIL x0_no_bypass: got %h want 00000000", rf_if.rs1_data);
    end
    tick();
    rf_if.wb_en = 1'b0;
  endtask

  task automatic test_same_operands();
    wr(5'd4, 32'h80000000);
    rf_if.instr = mk_instr(5'd4, 5'd4);
    #1;
    checks++;
    if (rf_if.rs1_data !== 32'h80000000 || rf_if.rs2_data !== 32'h80000000) begin
      errors++;
      $display("FAIL same_ops: got %h/%h want 80000000/80000000", rf_if.rs1_data, rf_if.rs2_data);
    end
  endtask

  task automatic test_read_during_write();
    logic [31:0] exp_pre;
`ifdef RF_BYPASS_EN
    exp_pre = 32'h0000000B;
`else
    exp_pre = 32'h0000000A;
`endif
    wr(5'd6, 32'h0000000A);
    rf_if.instr    = mk_instr(5'd6, 5'd6);
    rf_if.dbg_addr = 5'd6;
    rf_if.wb_en    = 1'b1;
    rf_if.wb_rd    = 5'd6;
    rf_if.wb_data  = 32'h0000000B;
    #1;
    checks++;
    if (rf_if.rs1_data !== exp_pre || rf_if.rs2_data !== exp_pre) begin
      errors++;
      $display("FAIL rdw_pre: got %h/%h want %h", rf_if.rs1_data, rf_if.rs2_data, exp_pre);
    end
    checks++;
    if (rf_if.dbg_data !== 32'h0000000A) begin
      errors++;
      $display("FAIL rdw_dbg_pre: got %h want 0000000a", rf_if.dbg_data);
    end
    tick();
    rf_if.wb_en = 1'b0;
    #1;
    checks++;
    if (rf_if.rs1_data !== 32'h0000000B || rf_if.dbg_data !== 32'h0000000B) begin
      errors++;
      $display("FAIL rdw_post: got %h/%h want 0000000b", rf_if.rs1_data, rf_if.dbg_data);
    end
    // wb_en low: no forward, no update.
    rf_if.wb_rd   = 5'd6;
    rf_if.wb_data = 32'h0000000C;
    #1;
    checks++;
    if (rf_if.rs1_data !== 32'h0000000B) begin
      errors++;
      $display("FAIL wben0_pre: got %h want 0000000b", rf_if.rs1_data);
    end
    tick();
    checks++;
    if (rf_if.rs1_data !== 32'h0000000B || rf_if.dbg_data !== 32'h0000000B) begin
      errors++;
      $display("FAIL wben0_post: got %h/%h want 0000000b", rf_if.rs1_data, rf_if.dbg_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    for (int i = 1; i < 32; i++) begin
      wr(5'(i), 32'(i) * 32'h01010101);
    end
    for (int i = 0; i < 32; i++) begin
      exp            = 32'(i) * 32'h01010101;
      rf_if.dbg_addr = 5'(i);
      rf_if.instr    = mk_instr(5'd0, 5'(i));
      #1;
      checks++;
      if (rf_if.dbg_data !== exp || rf_if.rs2_data !== exp) begin
        errors++;
        $display("FAIL sweep x%0d: got dbg %h rs2 %h want %h", i, rf_if.dbg_data, rf_if.rs2_data, exp);
      end
    end
  endtask

  task automatic test_reset_midstream();
    rf_if.wb_en   = 1'b1;
    rf_if.wb_rd   = 5'd9;
    rf_if.wb_data = 32'h55AA55AA;
    rst           = 1'b1;
    tick();
    rst         = 1'b0;
    rf_if.wb_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rf_if.dbg_addr = 5'(i);
      #1;
      checks++;
      if (rf_if.dbg_data !== 32'h0) begin
        errors++;
        $display("FAIL midreset x%0d: got %h want 00000000", i, rf_if.dbg_data);
      end
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    rf_if.instr    = '0;
    rf_if.wb_en    = 1'b0;
    rf_if.wb_rd    = '0;
    rf_if.wb_data  = '0;
    rf_if.dbg_addr = '0;
    test_reset();
    test_write_read();
    test_x0();
    test_same_operands();
    test_read_during_write();
    test_back_to_back();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
